// File: rtl/ripple_mon_pkg.sv
// Shared types and default sizing for the ripple counter monitor.
package ripple_mon_pkg;

    // Default width of the monitored count, the lap counter and the filter depth.
    localparam int unsigned MON_WIDTH         = 4;
    localparam int unsigned MON_LAP_W         = 8;
    localparam int unsigned MON_STABLE_CYCLES = 2;

    // Monitor FSM: waiting for the first stable value, then tracking decrements.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Bitwise two-flop synchronizer for asynchronous inputs.
// Ports:
//   clock, reset : system clock, synchronous active-high reset (stages clear to 0)
//   d            : asynchronous input bits
//   q            : synchronized output (second stage)
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    // First stage may go metastable; only the second stage is consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Synchronous monitor for a ripple down-counter: synchronizes, filters ripple
// transients, and classifies each accepted value as step, wrap, resync or error.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   count_in     : raw ripple counter output (asynchronous)
//   enable       : gates acceptance and pulses; filter keeps running
//   clear_err    : clears the sticky error flag (a new error wins)
//   count_out    : last accepted stable count
//   valid        : a first value has been accepted
//   step/wrap/resync : one-cycle classification pulses
//   laps         : saturating wrap counter
//   error        : sticky illegal-jump flag
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int unsigned WIDTH         = MON_WIDTH,
    parameter int unsigned LAP_W         = MON_LAP_W,
    parameter int unsigned STABLE_CYCLES = MON_STABLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             enable,
    input  logic             clear_err,
    output logic [WIDTH-1:0] count_out,
    output logic             valid,
    output logic             step,
    output logic             wrap,
    output logic             resync,
    output logic [LAP_W-1:0] laps,
    output logic             error
);

    localparam int unsigned     RUN_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [LAP_W-1:0] LAPS_MAX = '1;

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] hist;
    logic [RUN_W-1:0] run_prev;
    logic [RUN_W-1:0] run;
    logic             primed;

    mon_state_t       state, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_dec;
    logic [LAP_W-1:0] laps_d;
    logic             valid_d, step_d, wrap_d, resync_d, error_d;
    logic             accept;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (count_in),
        .q     (s2)
    );

    // Length of the current run of identical s2 samples, saturating.
    always_comb begin
        if (s2 != hist) begin
            run = RUN_W'(1);
        end else if (run_prev == RUN_MAX) begin
            run = RUN_MAX;
        end else begin
            run = run_prev + RUN_W'(1);
        end
    end

    // Filter history; the cycle leaving reset does not count toward a run,
    // so the cleared s2/hist pair can never look like a stable zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist     <= '0;
            run_prev <= '0;
            primed   <= 1'b0;
        end else begin
            hist     <= s2;
            run_prev <= primed ? run : '0;
            primed   <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, acceptance and classification.
    always_comb begin
        state_d   = state;
        count_d   = count_out;
        valid_d   = valid;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        resync_d  = 1'b0;
        laps_d    = laps;
        error_d   = error & ~clear_err;
        count_dec = WIDTH'(count_out - WIDTH'(1));
        accept    = enable && (run == RUN_MAX) &&
                    ((s2 != count_out) || (state == ST_INIT));

        case (state)
            ST_INIT: begin
                valid_d = 1'b0;
                if (accept) begin
                    count_d = s2;
                    valid_d = 1'b1;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    count_d = s2;
                    if (s2 == count_dec) begin
                        step_d = 1'b1;
                        if (count_out == '0) begin
                            wrap_d = 1'b1;
                            if (laps != LAPS_MAX) begin
                                laps_d = laps + LAP_W'(1);
                            end
                        end
                    end else if (s2 == '0) begin
                        resync_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_out <= '0;
            valid     <= 1'b0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            resync    <= 1'b0;
            laps      <= '0;
            error     <= 1'b0;
        end else begin
            count_out <= count_d;
            valid     <= valid_d;
            step      <= step_d;
            wrap      <= wrap_d;
            resync    <= resync_d;
            laps      <= laps_d;
            error     <= error_d;
        end
    end

endmodule
